// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS ALU datapath: opcodes, ALU controls, sequencer states, field positions.
// Used by the sequencer, decoder, ALU and register file.
package mips_pkg;

    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_SUB  = 6'b000110;
    localparam logic [5:0] OP_SLT  = 6'b000111;
    localparam logic [5:0] OP_NOR  = 6'b001100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_NOR = 4'hC;

    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_e;

endpackage

// File: rtl/mips_decoder.sv
// Combinational R-type decode: IR -> register addresses, ALU control, halt/illegal flags.
// Zero latency; shamt and funct are not used by this datapath.
module mips_decoder
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [3:0]  alu_ctrl,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [5:0] op;
    logic       unused_fields;

    assign op            = ir[OP_LSB +: 6];
    assign rs            = ir[RS_LSB +: 5];
    assign rt            = ir[RT_LSB +: 5];
    assign rd            = ir[RD_LSB +: 5];
    assign unused_fields = ^ir[RD_LSB-1:0];

    always_comb begin
        alu_ctrl   = ALU_AND;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_AND:  alu_ctrl = ALU_AND;
            OP_OR:   alu_ctrl = ALU_OR;
            OP_ADD:  alu_ctrl = ALU_ADD;
            OP_SUB:  alu_ctrl = ALU_SUB;
            OP_SLT:  alu_ctrl = ALU_SLT;
            OP_NOR:  alu_ctrl = ALU_NOR;
            OP_HALT: is_halt  = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control for the MIPS ALU datapath.
// 4 cycles per instruction with immediate ACK and EXEC_CYCLES=1; FETCH waits indefinitely for INSTR_ACK.
module mips_alu_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          PC_STEP     = 4,
    parameter logic [31:0] END_PC      = 32'd24,
    parameter int          EXEC_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        INSTR_REQ,
    input  logic        INSTR_ACK,
    input  logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [4:0]  RF_RADDR_A,
    output logic [4:0]  RF_RADDR_B,
    output logic [4:0]  RF_WADDR,
    output logic        RF_WE,
    output logic [3:0]  ALU_CTRL,
    output logic        BUSY,
    output logic        HALTED,
    output logic        ILLEGAL,
    output logic [15:0] INSTR_COUNT
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  exec_cnt_q, exec_cnt_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;
    logic [32:0] pc_sum;
    logic        dec_halt, dec_illegal;

    // Register addresses and ALU control are decoded straight from the held IR,
    // so they appear in DECODE and stay put until the next fetch completes.
    mips_decoder u_decoder (
        .ir         (ir_q),
        .rs         (RF_RADDR_A),
        .rt         (RF_RADDR_B),
        .rd         (RF_WADDR),
        .alu_ctrl   (ALU_CTRL),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            ir_q       <= 32'h0;
            pc_q       <= RESET_PC;
            exec_cnt_q <= 4'd0;
            count_q    <= 16'd0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            exec_cnt_q <= exec_cnt_d;
            count_q    <= count_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        exec_cnt_d = exec_cnt_q;
        count_d    = count_q;
        illegal_d  = illegal_q;
        pc_sum     = {1'b0, pc_q} + 33'(PC_STEP);
        case (state_q)
            S_IDLE, S_HALT: begin
                if (START) begin
                    state_d   = S_FETCH;
                    pc_d      = RESET_PC;
                    illegal_d = 1'b0;
                    count_d   = 16'd0;
                end
            end
            S_FETCH: begin
                if (INSTR_ACK) begin
                    ir_d    = INSTRUCTION;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_WRITEBACK;
                end else begin
                    exec_cnt_d = EXEC_LOAD;
                    state_d    = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (exec_cnt_q == 4'd0) begin
                    state_d = S_WRITEBACK;
                end else begin
                    exec_cnt_d = exec_cnt_q - 4'd1;
                end
            end
            S_WRITEBACK: begin
                pc_d = pc_sum[31:0];
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                // Halt on the end address or when the PC wraps around the address space.
                if (pc_sum[31:0] == END_PC || pc_sum[32]) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        INSTR_REQ   = 1'b0;
        RF_WE       = 1'b0;
        BUSY        = 1'b0;
        HALTED      = 1'b0;
        PC_OUT      = pc_q;
        ILLEGAL     = illegal_q;
        INSTR_COUNT = count_q;
        case (state_q)
            S_FETCH:     begin INSTR_REQ = 1'b1; BUSY = 1'b1; end
            S_DECODE:    BUSY = 1'b1;
            S_EXECUTE:   BUSY = 1'b1;
            S_WRITEBACK: begin
                BUSY  = 1'b1;
                RF_WE = !dec_illegal && (RF_WADDR != 5'd0);
            end
            S_HALT:      HALTED = 1'b1;
            default:     BUSY = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mips_alu_sequencer.sv
// Directed bench for mips_alu_sequencer: instruction-level program model plus per-cycle compare process.
// A second instance with EXEC_CYCLES=3 covers multi-cycle execute and reset mid-instruction.
module tb_mips_alu_sequencer;

    logic        clk, rst_n;
    logic        start_a, ack_a, req_a, we_a, busy_a, halted_a, ill_a;
    logic [31:0] instr_a, pc_a;
    logic [4:0]  ra_a, rb_a, wa_a;
    logic [3:0]  ctrl_a;
    logic [15:0] cnt_a;
    logic        start_b, ack_b, req_b, we_b, busy_b, halted_b, ill_b;
    logic [31:0] instr_b, pc_b;
    logic [4:0]  ra_b, rb_b, wa_b;
    logic [3:0]  ctrl_b;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_dly = 0;
    bit spur_ack = 0;
    bit chk_en = 0;
    int wait_a = 0;
    int we_b_n = 0;
    logic req_prev = 0;
    logic we_prev  = 0;

    logic [31:0] imem [16];
    logic [31:0] fetch_q [$];
    logic [18:0] wr_q [$];
    logic [3:0]  we_ctrl [$];
    int          we_cyc [$];
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_ill;

    localparam logic [3:0] EXP_CTRL [6] = '{4'h2, 4'h0, 4'h1, 4'h6, 4'h7, 4'hC};

    mips_alu_sequencer #(.RESET_PC(32'h0), .PC_STEP(4), .END_PC(32'd24), .EXEC_CYCLES(1)) dut_a (
        .CLK(clk), .RESET(rst_n), .START(start_a), .INSTR_REQ(req_a), .INSTR_ACK(ack_a),
        .INSTRUCTION(instr_a), .PC_OUT(pc_a), .RF_RADDR_A(ra_a), .RF_RADDR_B(rb_a),
        .RF_WADDR(wa_a), .RF_WE(we_a), .ALU_CTRL(ctrl_a), .BUSY(busy_a), .HALTED(halted_a),
        .ILLEGAL(ill_a), .INSTR_COUNT(cnt_a)
    );

    mips_alu_sequencer #(.RESET_PC(32'h0), .PC_STEP(4), .END_PC(32'd24), .EXEC_CYCLES(3)) dut_b (
        .CLK(clk), .RESET(rst_n), .START(start_b), .INSTR_REQ(req_b), .INSTR_ACK(ack_b),
        .INSTRUCTION(instr_b), .PC_OUT(pc_b), .RF_RADDR_A(ra_b), .RF_RADDR_B(rb_b),
        .RF_WADDR(wa_b), .RF_WE(we_b), .ALU_CTRL(ctrl_b), .BUSY(busy_b), .HALTED(halted_b),
        .ILLEGAL(ill_b), .INSTR_COUNT(cnt_b)
    );

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory for instance A: ACK after ack_dly waiting cycles, optional stray ACK while idle.
    initial begin
        ack_a = 0;
        instr_a = 32'h0;
        forever begin
            @(negedge clk);
            if (req_a) begin
                if (wait_a >= ack_dly) begin
                    ack_a = 1;
                    instr_a = imem[pc_a[5:2]];
                end else begin
                    ack_a = 0;
                    wait_a++;
                end
            end else begin
                wait_a = 0;
                ack_a = spur_ack;
                instr_a = enc(6'b000010, 5'd31, 5'd31, 5'd31);
            end
        end
    end

    initial begin
        ack_b = 0;
        instr_b = 32'h0;
        forever begin
            @(negedge clk);
            ack_b = req_b;
            instr_b = req_b ? imem[pc_b[5:2]] : 32'h0;
            if (we_b) we_b_n++;
        end
    end

    // Per-cycle compare of instance A against the program model's fetch and write queues.
    always @(negedge clk) begin
        if (chk_en) begin
            if (req_a && !req_prev) begin
                if (fetch_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_extra: fetch of pc %0h, none expected", pc_a);
                end else begin
                    chk("fetch_pc", pc_a, fetch_q.pop_front());
                end
            end
            if (we_a) begin
                we_ctrl.push_back(ctrl_a);
                we_cyc.push_back(cyc);
                chk("we_one_cycle", {30'd0, we_prev, we_a}, 32'd1);
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_extra: write to r%0d, none expected", wa_a);
                end else begin
                    chk("write_fields", {13'd0, wa_a, ra_a, rb_a, ctrl_a}, {13'd0, wr_q.pop_front()});
                end
            end
            if (halted_a) chk("halt_quiet", {29'd0, busy_a, req_a, we_a}, 32'd0);
        end
        req_prev = req_a;
        we_prev  = we_a;
    end

    task automatic load_base();
        for (int i = 0; i < 16; i++) imem[i] = enc(6'b111111, 5'd0, 5'd0, 5'd0);
        imem[0] = enc(6'b000010, 5'd2, 5'd3, 5'd1);
        imem[1] = enc(6'b000000, 5'd5, 5'd6, 5'd4);
        imem[2] = enc(6'b000001, 5'd8, 5'd9, 5'd7);
        imem[3] = enc(6'b000110, 5'd11, 5'd12, 5'd10);
        imem[4] = enc(6'b000111, 5'd14, 5'd15, 5'd13);
        imem[5] = enc(6'b001100, 5'd17, 5'd18, 5'd16);
    endtask

    // Walk the program as the architecture defines it and record what must be seen.
    task automatic build_model();
        logic [31:0] w;
        logic [3:0]  c;
        bit legal, halt;
        fetch_q.delete();
        wr_q.delete();
        we_ctrl.delete();
        we_cyc.delete();
        m_pc = 32'h0;
        m_cnt = 0;
        m_ill = 0;
        for (int n = 0; n < 64; n++) begin
            fetch_q.push_back(m_pc);
            w = imem[m_pc[5:2]];
            legal = 1;
            halt = 0;
            c = 4'h0;
            case (w[31:26])
                6'd0:  c = 4'd0;
                6'd1:  c = 4'd1;
                6'd2:  c = 4'd2;
                6'd6:  c = 4'd6;
                6'd7:  c = 4'd7;
                6'd12: c = 4'd12;
                6'd63: halt = 1;
                default: legal = 0;
            endcase
            if (halt) break;
            if (legal && w[15:11] != 5'd0) wr_q.push_back({w[15:11], w[25:21], w[20:16], c});
            if (!legal) m_ill = 1;
            m_cnt++;
            m_pc = m_pc + 32'd4;
            if (m_pc == 32'd24) break;
        end
    endtask

    task automatic run_prog(input int dly, input bit spur, input int busy_k);
        build_model();
        ack_dly = dly;
        spur_ack = spur;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        chk("restart_busy", {31'd0, busy_a}, 32'd1);
        chk("restart_count", {16'd0, cnt_a}, 32'd0);
        chk("restart_pc", pc_a, 32'd0);
        for (int k = 0; k < 3000 && !halted_a; k++) begin
            start_a = (k == busy_k);
            @(negedge clk);
        end
        start_a = 0;
        chk("run_halted", {31'd0, halted_a}, 32'd1);
        chk("final_pc", pc_a, m_pc);
        chk("final_count", {16'd0, cnt_a}, m_cnt);
        chk("final_illegal", {31'd0, ill_a}, {31'd0, m_ill});
        chk("fetch_q_drained", fetch_q.size(), 32'd0);
        chk("write_q_drained", wr_q.size(), 32'd0);
    endtask

    task automatic check_log(input int period);
        chk("we_pulses", we_ctrl.size(), 32'd6);
        for (int i = 0; i < we_ctrl.size() && i < 6; i++) chk("alu_seq", {28'd0, we_ctrl[i]}, {28'd0, EXP_CTRL[i]});
        for (int i = 1; i < we_cyc.size(); i++) chk("we_period", we_cyc[i] - we_cyc[i-1], period);
    endtask

    initial begin
        int c0, n0;
        rst_n = 0;
        start_a = 0;
        start_b = 0;
        load_base();
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, req_a}, 32'd0);
        chk("rst_pc", pc_a, 32'd0);
        chk("rst_addrs", {17'd0, ra_a, rb_a, wa_a}, 32'd0);
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_ctrl", {28'd0, ctrl_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_halted", {31'd0, halted_a}, 32'd0);
        chk("rst_illegal", {31'd0, ill_a}, 32'd0);
        chk("rst_count", {16'd0, cnt_a}, 32'd0);
        rst_n = 1;
        chk_en = 1;
        repeat (3) @(negedge clk);
        chk("idle_wait", {30'd0, busy_a, req_a}, 32'd0);

        // Six-instruction program, immediate ACK.
        run_prog(0, 0, -1);
        check_log(4);
        chk("t1_pc", pc_a, 32'd24);
        chk("t1_count", {16'd0, cnt_a}, 32'd6);

        // Slow memory (3 wait cycles) with stray ACKs outside FETCH.
        run_prog(3, 1, -1);
        check_log(7);
        chk("t2_count", {16'd0, cnt_a}, 32'd6);
        spur_ack = 0;

        // Undefined opcode at address 4.
        imem[1] = enc(6'b101010, 5'd5, 5'd6, 5'd4);
        run_prog(0, 0, -1);
        chk("t3_illegal", {31'd0, ill_a}, 32'd1);
        chk("t3_we_pulses", we_ctrl.size(), 32'd5);
        chk("t3_count", {16'd0, cnt_a}, 32'd6);

        // ADD targeting r0 at address 0.
        load_base();
        imem[0] = enc(6'b000010, 5'd2, 5'd3, 5'd0);
        run_prog(0, 0, -1);
        chk("t4_we_pulses", we_ctrl.size(), 32'd5);
        chk("t4_pc", pc_a, 32'd24);
        chk("t4_illegal_cleared", {31'd0, ill_a}, 32'd0);

        // HALT at address 8, then restart from HALT with a START pulse while busy.
        load_base();
        imem[2] = enc(6'b111111, 5'd0, 5'd0, 5'd0);
        run_prog(0, 0, -1);
        chk("t5_pc", pc_a, 32'd8);
        chk("t5_count", {16'd0, cnt_a}, 32'd2);
        run_prog(0, 0, 6);
        chk("t5b_pc", pc_a, 32'd8);
        chk("t5b_count", {16'd0, cnt_a}, 32'd2);
        chk("t5b_we_pulses", we_ctrl.size(), 32'd2);
        chk_en = 0;

        // Instance B: EXEC_CYCLES=3 stretches the first write to 5 cycles after fetch.
        load_base();
        @(negedge clk);
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        c0 = cyc;
        for (int k = 0; k < 50 && !we_b; k++) @(negedge clk);
        chk("b_first_we_latency", cyc - c0, 32'd5);
        for (int k = 0; k < 200 && !halted_b; k++) @(negedge clk);
        chk("b_count", {16'd0, cnt_b}, 32'd6);
        chk("b_pc", pc_b, 32'd24);

        // Reset in the middle of EXECUTE.
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        n0 = we_b_n;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("b_pre_reset", {27'd0, busy_b, req_b, ctrl_b}, {27'd0, 1'b1, 1'b0, 4'h2});
        rst_n = 0;
        #1;
        chk("b_rst_busy", {31'd0, busy_b}, 32'd0);
        chk("b_rst_we", {31'd0, we_b}, 32'd0);
        chk("b_rst_ctrl_addr", {13'd0, ctrl_b, ra_b, rb_b, wa_b}, 32'd0);
        chk("b_rst_pc_cnt", pc_b | {16'd0, cnt_b}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        chk("b_idle_after_reset", {29'd0, busy_b, req_b, halted_b}, 32'd0);
        chk("b_no_write_on_abort", we_b_n - n0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
